// File: rtl/uart_baud_gen_frac.sv
// Fractional baud-rate generator: oversample tick, mid-bit and bit ticks,
// shadowed divisor reload applied on period boundaries, RX phase re-sync.
module uart_baud_gen_frac #(
  parameter int DIV_W    = 16,
  parameter int FRAC_W   = 4,
  parameter int OSR      = 16,
  parameter int DEF_DIV  = 27,
  parameter int DEF_FRAC = 2,
  localparam int PH_W    = $clog2(OSR)
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              En,
  input  logic              Sync,
  input  logic              Load,
  input  logic [DIV_W-1:0]  Divisor,
  input  logic [FRAC_W-1:0] Frac,
  output logic              Tick,
  output logic              MidTick,
  output logic              BitTick,
  output logic [PH_W-1:0]   Phase,
  output logic              LoadPend,
  output logic              CfgErr
);

  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              ext_q, ext_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [DIV_W-1:0]  div_act_q, div_act_d;
  logic [FRAC_W-1:0] frac_act_q, frac_act_d;
  logic [DIV_W-1:0]  shd_div_q, shd_div_d;
  logic [FRAC_W-1:0] shd_frac_q, shd_frac_d;
  logic              pend_q, pend_d;
  logic              tick_q, tick_d;
  logic              mid_q, mid_d;
  logic              bit_q, bit_d;
  logic              err_q, err_d;

  logic [DIV_W:0]    limit;
  logic [DIV_W:0]    cnt_nxt;
  logic [FRAC_W:0]   acc_sum;
  logic              at_end;
  logic              run;
  logic              tick_edge;
  logic              apply;

  always_comb begin
    limit     = {1'b0, div_act_q} + {{DIV_W{1'b0}}, ext_q};
    cnt_nxt   = {1'b0, cnt_q} + {{DIV_W{1'b0}}, 1'b1};
    // >= so a shortened divisor never lets a resumed period run past it
    at_end    = cnt_nxt >= limit;
    run       = En & ~err_q & ~Sync;
    tick_edge = run & at_end;
    apply     = pend_q & (tick_edge | ~En | err_q | Sync);
    acc_sum   = {1'b0, acc_q} + {1'b0, frac_act_q};

    cnt_d      = cnt_q;
    acc_d      = acc_q;
    ext_d      = ext_q;
    phase_d    = phase_q;
    div_act_d  = div_act_q;
    frac_act_d = frac_act_q;
    shd_div_d  = shd_div_q;
    shd_frac_d = shd_frac_q;
    pend_d     = pend_q;
    tick_d     = 1'b0;
    mid_d      = 1'b0;
    bit_d      = 1'b0;

    if (Sync) begin
      cnt_d   = '0;
      acc_d   = '0;
      ext_d   = 1'b0;
      phase_d = '0;
    end else if (run) begin
      if (at_end) begin
        cnt_d   = '0;
        tick_d  = 1'b1;
        mid_d   = phase_q == PH_W'(OSR/2 - 1);
        bit_d   = phase_q == PH_W'(OSR - 1);
        acc_d   = acc_sum[FRAC_W-1:0];
        ext_d   = acc_sum[FRAC_W];
        phase_d = bit_d ? '0 : phase_q + PH_W'(1);
      end else begin
        cnt_d = cnt_nxt[DIV_W-1:0];
      end
    end

    if (apply) begin
      div_act_d  = shd_div_q;
      frac_act_d = shd_frac_q;
      pend_d     = 1'b0;
    end

    if (Load) begin
      shd_div_d  = Divisor;
      shd_frac_d = Frac;
      pend_d     = 1'b1;
    end

    err_d = div_act_d < DIV_W'(2);
    if (err_d) begin
      cnt_d   = '0;
      phase_d = '0;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_q      <= '0;
      acc_q      <= '0;
      ext_q      <= 1'b0;
      phase_q    <= '0;
      div_act_q  <= DIV_W'(DEF_DIV);
      frac_act_q <= FRAC_W'(DEF_FRAC);
      shd_div_q  <= DIV_W'(DEF_DIV);
      shd_frac_q <= FRAC_W'(DEF_FRAC);
      pend_q     <= 1'b0;
      tick_q     <= 1'b0;
      mid_q      <= 1'b0;
      bit_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      ext_q      <= ext_d;
      phase_q    <= phase_d;
      div_act_q  <= div_act_d;
      frac_act_q <= frac_act_d;
      shd_div_q  <= shd_div_d;
      shd_frac_q <= shd_frac_d;
      pend_q     <= pend_d;
      tick_q     <= tick_d;
      mid_q      <= mid_d;
      bit_q      <= bit_d;
      err_q      <= err_d;
    end
  end

  assign Tick     = tick_q;
  assign MidTick  = mid_q;
  assign BitTick  = bit_q;
  assign Phase    = phase_q;
  assign LoadPend = pend_q;
  assign CfgErr   = err_q;

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// Bench for uart_baud_gen_frac: per-cycle reference model plus
// directed period/phase scenarios and randomized traffic.
module tb_uart_baud_gen_frac;
  localparam int OSR = 16;
  localparam int FR  = 16;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        En = 1'b0;
  logic        Sync = 1'b0;
  logic        Load = 1'b0;
  logic [15:0] Divisor = '0;
  logic [3:0]  Frac = '0;
  logic        Tick, MidTick, BitTick, LoadPend, CfgErr;
  logic [3:0]  Phase;

  uart_baud_gen_frac dut (
    .Clk(Clk), .Rst_n(Rst_n), .En(En), .Sync(Sync), .Load(Load),
    .Divisor(Divisor), .Frac(Frac), .Tick(Tick), .MidTick(MidTick),
    .BitTick(BitTick), .Phase(Phase), .LoadPend(LoadPend), .CfgErr(CfgErr)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int fails = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: elapsed cycles in period, fractional remainder, etc.
  int m_el = 0, m_acc = 0, m_ext = 0, m_ph = 0;
  int m_div = 27, m_frac = 2, m_sdiv = 27, m_sfrac = 2;
  int m_pend = 0, m_err = 0;
  int e_tick = 0, e_mid = 0, e_bit = 0;
  int lim, sum;
  bit tk, app;

  initial forever begin
    @(posedge Clk or negedge Rst_n);
    if (!Rst_n) begin
      m_el = 0; m_acc = 0; m_ext = 0; m_ph = 0;
      m_div = 27; m_frac = 2; m_sdiv = 27; m_sfrac = 2;
      m_pend = 0; m_err = 0;
      e_tick = 0; e_mid = 0; e_bit = 0;
    end else begin
      lim = m_div + m_ext;
      tk  = En && m_err == 0 && !Sync && (m_el + 1 >= lim);
      app = m_pend != 0 && (tk || !En || m_err != 0 || Sync);
      e_tick = 0; e_mid = 0; e_bit = 0;
      if (Sync) begin
        m_el = 0; m_acc = 0; m_ext = 0; m_ph = 0;
      end else if (En && m_err == 0) begin
        if (tk) begin
          e_tick = 1;
          e_mid = (m_ph == OSR / 2 - 1) ? 1 : 0;
          e_bit = (m_ph == OSR - 1) ? 1 : 0;
          sum = m_acc + m_frac;
          m_ext = sum / FR;
          m_acc = sum % FR;
          m_ph = (m_ph + 1) % OSR;
          m_el = 0;
        end else m_el++;
      end
      if (app) begin
        m_div = m_sdiv; m_frac = m_sfrac; m_pend = 0;
      end
      if (Load) begin
        m_sdiv = int'(Divisor); m_sfrac = int'(Frac); m_pend = 1;
      end
      m_err = (m_div < 2) ? 1 : 0;
      if (m_err != 0) begin
        m_el = 0; m_ph = 0;
      end
    end
  end

  initial forever begin
    @(negedge Clk);
    chk("Tick", Tick, e_tick);
    chk("MidTick", MidTick, e_mid);
    chk("BitTick", BitTick, e_bit);
    chk("Phase", Phase, m_ph);
    chk("LoadPend", LoadPend, m_pend);
    chk("CfgErr", CfgErr, m_err);
  end

  int n;
  int tq[$], mq[$], bq[$];

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic clr();
    n = 0;
    tq.delete(); mq.delete(); bq.delete();
  endtask

  task automatic run(input int nc);
    En = 1'b1;
    repeat (nc) begin
      step();
      n++;
      if (Tick) tq.push_back(n);
      if (MidTick) mq.push_back(n);
      if (BitTick) bq.push_back(n);
    end
  endtask

  task automatic cfg(input int d, input int f);
    En = 1'b0; Sync = 1'b0;
    Divisor = 16'(d); Frac = 4'(f);
    Load = 1'b1; step(); Load = 1'b0;
    step();
    Sync = 1'b1; step(); Sync = 1'b0;
    clr();
  endtask

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  initial begin
    #3;
    chk("rst_tick", Tick, 0);
    chk("rst_phase", Phase, 0);
    chk("rst_pend", LoadPend, 0);
    chk("rst_err", CfgErr, 0);
    #9 Rst_n = 1'b1;
    step();

    cfg(4, 0);
    run(64);
    chk("t1_first", qat(tq, 0), 4);
    chk("t1_ntick", tq.size(), 16);
    chk("t1_mid", qat(mq, 0), 32);
    chk("t1_bit", qat(bq, 0), 64);
    chk("t1_wrap", Phase, 0);

    cfg(4, 8);
    run(143);
    chk("t2_n", tq.size(), 32);
    chk("t2_last", qat(tq, 31), 143);

    cfg(10, 0);
    run(13);
    Divisor = 16'd6; Load = 1'b1;
    run(1);
    Load = 1'b0;
    chk("t3_pend", LoadPend, 1);
    run(30);
    chk("t3_old", qat(tq, 1), 20);
    chk("t3_new", qat(tq, 2), 26);
    chk("t3_new2", qat(tq, 3), 32);
    chk("t3_clr", LoadPend, 0);

    cfg(4, 0);
    run(28);
    chk("t4_pre", Phase, 7);
    Sync = 1'b1; step(); Sync = 1'b0;
    chk("t4_sync", Phase, 0);
    clr();
    run(64);
    chk("t4_first", qat(tq, 0), 4);
    chk("t4_mid", qat(mq, 0), 32);
    chk("t4_bit", qat(bq, 0), 64);

    cfg(1, 0);
    chk("t5_err", CfgErr, 1);
    run(100);
    chk("t5_quiet", tq.size(), 0);
    cfg(3, 0);
    chk("t5_ok", CfgErr, 0);
    run(9);
    chk("t5_a", qat(tq, 0), 3);
    chk("t5_c", qat(tq, 2), 9);

    for (int i = 0; i < 3000; i++) begin
      En = ($urandom_range(0, 9) != 0);
      Sync = ($urandom_range(0, 199) == 0);
      Load = ($urandom_range(0, 59) == 0);
      Divisor = ($urandom_range(0, 19) == 0) ? 16'($urandom_range(0, 1))
                                               : 16'($urandom_range(2, 12));
      Frac = 4'($urandom);
      step();
    end
    Load = 1'b0; Sync = 1'b0;

    cfg(2, 15);
    run(2);
    Divisor = 16'hFFFF; Frac = 4'd15; Load = 1'b1;
    run(1);
    Load = 1'b0;
    run(1);
    run(65536);
    chk("t6_n", tq.size(), 3);
    chk("t6_max", qat(tq, 2), 65540);
    Divisor = 16'd5; Load = 1'b1;
    run(1);
    Load = 1'b0;
    run(50);
    chk("t6_pend", LoadPend, 1);
    #2 Rst_n = 1'b0;
    #1;
    chk("t6_rtick", Tick, 0);
    chk("t6_rphase", Phase, 0);
    chk("t6_rpend", LoadPend, 0);
    #2 Rst_n = 1'b1;
    clr();
    run(54);
    chk("t6_def1", qat(tq, 0), 27);
    chk("t6_def2", qat(tq, 1), 54);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
